// File: rtl/uart8250_rx.sv
// Receive half of the 8250-style UART: 8N1 deserialiser, small RX FIFO, and the RBR/LSR read port.
// The line is double-flopped; every sampling decision uses the synchronised copy.
module uart8250_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  input  logic       rvalid,
  input  logic [2:0] raddr,
  output logic [7:0] rdata,
  output logic       dr_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_C  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_C  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAITHI
  } state_t;

  logic            r_sync1, r_sync2;
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_bitidx, w_bitidx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic            r_oe, r_fe;
  logic [7:0]      r_rdata;

  logic            w_rx_s;
  logic            w_push, w_fe_set;
  logic            w_empty, w_full;
  logic            w_rd_rbr, w_rd_lsr;
  logic            w_pop, w_push_ok, w_oe_set;
  logic [7:0]      w_lsr;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitidx <= w_bitidx_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  // Start is re-checked at mid-bit so short low glitches are rejected; every later sample is one bit apart.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt - CW'(1);
    w_bitidx_nxt = r_bitidx;
    w_shift_nxt  = r_shift;
    w_push       = 1'b0;
    w_fe_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = HALF_C;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          if (!w_rx_s) begin
            w_state_nxt  = S_DATA;
            w_cnt_nxt    = FULL_C;
            w_bitidx_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_cnt_nxt   = FULL_C;
          if (r_bitidx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bitidx_nxt = r_bitidx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          if (w_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_fe_set    = 1'b1;
            w_state_nxt = S_WAITHI;
          end
        end
      end
      S_WAITHI: begin
        w_cnt_nxt = r_cnt;
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read port: each cycle with rvalid=1 is exactly one read; its data and side effects land on that edge.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_rd_rbr  = rvalid && (raddr == 3'd0);
  assign w_rd_lsr  = rvalid && (raddr == 3'd5);
  assign w_pop     = w_rd_rbr && !w_empty;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_oe_set  = w_push && w_full && !w_pop;
  assign w_lsr     = {1'b0, 1'b1, 1'b1, 1'b0, r_fe, 1'b0, r_oe, !w_empty};

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error in the same cycle as the clearing LSR read keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_oe <= 1'b0;
      r_fe <= 1'b0;
    end else begin
      r_oe <= w_rd_lsr ? w_oe_set : (r_oe | w_oe_set);
      r_fe <= w_rd_lsr ? w_fe_set : (r_fe | w_fe_set);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rdata <= 8'h00;
    end else if (rvalid) begin
      case (raddr)
        3'd0:    r_rdata <= w_empty ? 8'h00 : r_mem[r_rptr];
        3'd5:    r_rdata <= w_lsr;
        default: r_rdata <= 8'h00;
      endcase
    end
  end

  assign rdata = r_rdata;
  assign dr_o  = !w_empty;

endmodule

// File: tb/tb_uart8250_rx.sv
// Bench for uart8250_rx: table of directed frames/reads, hand-timed corner sequences,
// and random frames/reads checked against a queue-based model of the receiver.
module tb_uart8250_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rstn;
  logic       rx_i;
  logic       rvalid;
  logic [2:0] raddr;
  logic [7:0] rdata;
  logic       dr_o;

  uart8250_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rx_i   (rx_i),
    .rvalid (rvalid),
    .raddr  (raddr),
    .rdata  (rdata),
    .dr_o   (dr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  bit         m_oe;
  bit         m_fe;
  int         n_checks;
  int         n_errors;

  typedef struct {
    bit         is_frame;
    logic [7:0] data;
    logic [2:0] addr;
    logic [7:0] exp_rd;
    logic       exp_dr;
  } vec_t;

  vec_t tbl[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Model of a register read: returns expected rdata and applies the read's side effects.
  function automatic logic [7:0] model_read(input logic [2:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == 3'd0) begin
      if (exp_q.size() > 0) v = exp_q.pop_front();
    end else if (a == 3'd5) begin
      v = 8'h60 | (m_fe ? 8'h08 : 8'h00) | (m_oe ? 8'h02 : 8'h00) | ((exp_q.size() != 0) ? 8'h01 : 8'h00);
      m_oe = 1'b0;
      m_fe = 1'b0;
    end
    return v;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_oe = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endfunction

  // All tasks enter and leave on a falling edge.
  task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output logic dr);
    raddr  = a;
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    d      = rdata;
    dr     = dr_o;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int low_extra);
    drive_frame(b, stop);
    if (!stop) begin
      rx_i = 1'b0;
      repeat (low_extra) @(negedge clk);
      rx_i = 1'b1;
    end
    repeat (4) @(negedge clk);
    model_frame(b, stop);
  endtask

  task automatic read_check(input logic [2:0] a, input string tag);
    logic [7:0] e;
    logic [7:0] d;
    logic       dr;
    e = model_read(a);
    bus_read(a, d, dr);
    check8({tag, " rdata"}, d, e);
    check8({tag, " dr_o"}, {7'b0, dr}, {7'b0, exp_q.size() != 0});
  endtask

  initial begin
    logic [7:0] d;
    logic       dr;
    logic [7:0] e;
    logic [7:0] rb;
    int         op;

    n_checks = 0;
    n_errors = 0;
    m_oe     = 1'b0;
    m_fe     = 1'b0;
    rstn     = 1'b0;
    rx_i     = 1'b1;
    rvalid   = 1'b0;
    raddr    = 3'd0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    check8("reset rdata", rdata, 8'h00);
    check8("reset dr_o", {7'b0, dr_o}, 8'h00);
    read_check(3'd5, "reset lsr");

    // Directed table: basic frame, then FIFO overflow with drain.
    tbl.push_back('{1'b1, 8'h55, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 3'd5, 8'h61, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 3'd0, 8'h55, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 3'd5, 8'h60, 1'b0});
    for (int i = 1; i <= 5; i++) tbl.push_back('{1'b1, 8'(i), 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 3'd3, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 3'd5, 8'h63, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 3'd0, 8'h01, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 3'd0, 8'h02, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 3'd0, 8'h03, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 3'd0, 8'h04, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 3'd0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 3'd5, 8'h60, 1'b0});

    foreach (tbl[i]) begin
      if (tbl[i].is_frame) begin
        send_frame(tbl[i].data, 1'b1, 0);
      end else begin
        e = model_read(tbl[i].addr);
        bus_read(tbl[i].addr, d, dr);
        check8($sformatf("tbl[%0d] rdata", i), d, tbl[i].exp_rd);
        check8($sformatf("tbl[%0d] dr_o", i), {7'b0, dr}, {7'b0, tbl[i].exp_dr});
      end
    end

    // Short low pulse must not start a frame; a following frame proves the receiver is idle again.
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check8("glitch dr_o", {7'b0, dr_o}, 8'h00);
    read_check(3'd5, "glitch lsr");
    send_frame(8'h5A, 1'b1, 0);
    read_check(3'd0, "post-glitch rbr");

    // Framing error followed by a long low line, then a clean frame.
    send_frame(8'hA5, 1'b0, 40);
    send_frame(8'h3C, 1'b1, 0);
    read_check(3'd5, "fe lsr");
    read_check(3'd0, "fe rbr");
    read_check(3'd5, "fe lsr clear");

    // Full FIFO with an RBR pop landing on the stop-bit sample edge of a 5th frame.
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    send_frame(8'h33, 1'b1, 0);
    send_frame(8'h44, 1'b1, 0);
    fork
      drive_frame(8'h77, 1'b1);
      begin
        repeat (2 + CPB / 2 + 9 * CPB) @(negedge clk);
        bus_read(3'd0, rb, dr);
      end
    join
    repeat (4) @(negedge clk);
    check8("edge pop rdata", rb, 8'h11);
    check8("edge pop dr_o", {7'b0, dr}, 8'h01);
    e = exp_q.pop_front();
    exp_q.push_back(8'h77);
    read_check(3'd5, "edge lsr");
    for (int i = 0; i < 4; i++) read_check(3'd0, $sformatf("edge rbr%0d", i));
    read_check(3'd0, "edge rbr empty");

    // Reset in the middle of data bit 3.
    send_frame(8'h99, 1'b1, 0);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_i = e[0] | (8'hC3 >> i) & 8'h01 ? ((8'hC3 >> i) & 1) != 0 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx_i = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rstn = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    m_oe = 1'b0;
    m_fe = 1'b0;
    repeat (20) @(negedge clk);
    check8("post-reset rdata", rdata, 8'h00);
    check8("post-reset dr_o", {7'b0, dr_o}, 8'h00);
    read_check(3'd5, "post-reset lsr");
    send_frame(8'hC3, 1'b1, 0);
    read_check(3'd0, "post-reset rbr");

    // Random frames and reads against the model.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        if ($urandom_range(0, 5) == 0) send_frame(8'($urandom), 1'b0, $urandom_range(0, 30));
        else send_frame(8'($urandom), 1'b1, 0);
      end else if (op < 7) begin
        read_check(3'd0, $sformatf("rnd%0d rbr", n));
      end else if (op < 9) begin
        read_check(3'd5, $sformatf("rnd%0d lsr", n));
      end else begin
        read_check(3'($urandom_range(0, 7)), $sformatf("rnd%0d any", n));
      end
    end
    while (exp_q.size() > 0) read_check(3'd0, "drain rbr");
    read_check(3'd5, "final lsr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
